// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access sequencer.
// State/op encodings, byte-lane constants and op decode.
package dmem_access_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_LW = 2'd0,
    OP_SW = 2'd1,
    OP_LB = 2'd2,
    OP_SB = 2'd3
  } op_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // sb wins over we, we wins over lb
  function automatic op_t decodeOp(
    input logic sb,
    input logic we,
    input logic lb
  );
    op_t op;
    if (sb)      op = OP_SB;
    else if (we) op = OP_SW;
    else if (lb) op = OP_LB;
    else         op = OP_LW;
    return op;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_byte_lane_unit.sv
// Little-endian byte extract (zero-extended) and
// single-lane merge of a 32-bit word.
module byte_lane_unit
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [7:0]  wrByte,
  input  logic [1:0]  lane,
  output logic [31:0] extByte,
  output logic [31:0] mergedWord
);

  always_comb begin
    extByte    = '0;
    mergedWord = word;
    unique case (lane)
      LANE0: begin
        extByte[7:0]     = word[7:0];
        mergedWord[7:0]  = wrByte;
      end
      LANE1: begin
        extByte[7:0]     = word[15:8];
        mergedWord[15:8] = wrByte;
      end
      LANE2: begin
        extByte[7:0]      = word[23:16];
        mergedWord[23:16] = wrByte;
      end
      LANE3: begin
        extByte[7:0]      = word[31:24];
        mergedWord[31:24] = wrByte;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data RAM sequencer: LW/SW/LB direct,
// SB as read-modify-write with one stall cycle.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic          sb,
  input  logic          lb,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  state_t      state, nextState;
  op_t         opReg, reqOp;
  logic [1:0]  laneReg;
  logic        latchEn;
  logic [31:0] extByte, mergedWord;
  logic        unusedAddr;

  assign reqOp      = decodeOp(sb, we, lb);
  assign mem_addr   = addr[AW+1:2];
  assign unusedAddr = ^addr[31:AW+2];

  byte_lane_unit uLane (
    .word      (mem_rdata),
    .wrByte    (wdata[7:0]),
    .lane      (laneReg),
    .extByte   (extByte),
    .mergedWord(mergedWord)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      opReg   <= OP_LW;
      laneReg <= LANE0;
    end else begin
      state <= nextState;
      if (latchEn) begin
        opReg   <= reqOp;
        laneReg <= addr[1:0];
      end
    end
  end

  always_comb begin
    nextState = state;
    latchEn   = 1'b0;
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rdata     = '0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (reqOp == OP_SW) begin
            mem_we    = 1'b1;
            mem_wdata = wdata;
          end else begin
            stall     = 1'b1;
            latchEn   = 1'b1;
            nextState = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        nextState = IDLE;
        unique case (opReg)
          OP_LB: rdata = extByte;
          OP_SB: begin
            mem_we    = 1'b1;
            mem_wdata = mergedWord;
          end
          default: rdata = mem_rdata;
        endcase
      end
    endcase
    // reset must also kill a pending SB write
    if (rst) begin
      stall     = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      rdata     = '0;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a
// word-array reference model and sync-read RAM.
module tb_dmem_access_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we, sb, lb;
  logic [31:0]   addr, wdata, rdata;
  logic          stall;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .sb       (sb),
    .lb       (lb),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram    [2**AW];
  logic [31:0] refMem [2**AW];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  typedef struct {
    bit          isLoad;
    logic [31:0] d;
  } cmp_t;

  wr_t  wrQ[$];
  cmp_t cmpQ[$];
  int   stallLog[$];
  int   nVec = 0;
  int   nBad = 0;
  bit   prevStall = 0;

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t  w;
    cmp_t c;
    if (rst) begin
      prevStall = 0;
      check("rst_stall", 32'(stall), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end else begin
      if (mem_we) begin
        if (wrQ.size() == 0) begin
          nVec++;
          nBad++;
          $display("FAIL unexpected_write: addr %h data %h, none due",
                   mem_addr, mem_wdata);
        end else begin
          w = wrQ.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(w.a));
          check("wr_data", mem_wdata, w.d);
        end
      end
      if (prevStall && !stall) begin
        if (cmpQ.size() == 0) begin
          nVec++;
          nBad++;
          $display("FAIL unexpected_completion: rdata %h, none due",
                   rdata);
        end else begin
          c = cmpQ.pop_front();
          if (c.isLoad) check("rdata", rdata, c.d);
        end
      end else if (!req) begin
        check("idle_stall", 32'(stall), 0);
        check("idle_mem_we", 32'(mem_we), 0);
        check("idle_rdata", rdata, 0);
      end
      prevStall = stall;
    end
  end

  task automatic doOp(
    input bit          w,
    input bit          s,
    input bit          l,
    input logic [31:0] a,
    input logic [31:0] d,
    input bit          dropReq
  );
    int            lane = int'(a[1:0]);
    logic [AW-1:0] wi   = a[AW+1:2];
    logic [31:0]   old  = refMem[wi];
    logic [31:0]   mask;
    bit            isSW = !s && w;
    req   = 1'b1;
    we    = w;
    sb    = s;
    lb    = l;
    addr  = a;
    wdata = d;
    if (s) begin
      mask       = 32'hFF << (8 * lane);
      refMem[wi] = (old & ~mask) | ((d & 32'hFF) << (8 * lane));
      cmpQ.push_back('{1'b0, 32'h0});
      wrQ.push_back('{wi, refMem[wi]});
    end else if (w) begin
      refMem[wi] = d;
      wrQ.push_back('{wi, d});
    end else if (l) begin
      cmpQ.push_back('{1'b1, (old >> (8 * lane)) & 32'hFF});
    end else begin
      cmpQ.push_back('{1'b1, old});
    end
    @(negedge clk);
    stallLog.push_back(int'(stall));
    check("issue_stall", 32'(stall), 32'(!isSW));
    @(posedge clk);
    #1;
    if (!isSW) begin
      if (dropReq) req = 1'b0;
      @(negedge clk);
      stallLog.push_back(int'(stall));
      check("wait_stall", 32'(stall), 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      req   = 1'b0;
      we    = 1'($urandom);
      sb    = 1'($urandom);
      lb    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    int          expPat[$];
    bit          ow, os, ol;
    logic [31:0] ra;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i]    = $urandom;
      refMem[i] = ram[i];
    end
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    sb    = 1'b0;
    lb    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    doOp(1, 0, 0, 32'h10, 32'hDEADBEEF, 0);
    doOp(0, 0, 0, 32'h10, 32'h0, 0);

    doOp(1, 0, 0, 32'h20, 32'h44332211, 0);
    for (int i = 0; i < 4; i++)
      doOp(0, 0, 1, 32'h20 + 32'(i), $urandom, 0);

    doOp(0, 1, 0, 32'h22, 32'hFFFFFFAA, 0);
    doOp(0, 0, 0, 32'h20, 32'h0, 0);
    check("sb_merge_model", refMem[8], 32'h44AA2211);

    doOp(1, 1, 1, 32'h25, 32'h12345677, 0);
    doOp(0, 0, 0, 32'h24, 32'h0, 0);

    idleCycles(20);

    req   = 1'b1;
    sb    = 1'b1;
    we    = 1'b0;
    lb    = 1'b0;
    addr  = 32'h21;
    wdata = 32'h55;
    @(negedge clk);
    check("rmo_issue_stall", 32'(stall), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rmo_stall", 32'(stall), 0);
    check("rmo_mem_we", 32'(mem_we), 0);
    req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rmo_ram_kept", ram[8], refMem[8]);
    doOp(0, 0, 0, 32'h20, 32'h0, 0);

    stallLog.delete();
    doOp(0, 1, 0, 32'h31, $urandom, 0);
    doOp(0, 0, 1, 32'h31, $urandom, 0);
    doOp(1, 0, 0, 32'h34, $urandom, 0);
    doOp(0, 0, 0, 32'h34, $urandom, 0);
    expPat = '{1, 0, 1, 0, 0, 1, 0};
    check("b2b_cycles", 32'(stallLog.size()), 32'(expPat.size()));
    for (int i = 0; i < expPat.size() && i < stallLog.size(); i++)
      check("b2b_stall_pat", 32'(stallLog[i]), 32'(expPat[i]));

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) idleCycles(1);
      ow = 1'($urandom);
      os = ($urandom_range(0, 3) == 0);
      ol = 1'($urandom);
      ra = ($urandom & 32'hFFFF_F000)
         | (32'($urandom_range(0, 15)) << 2)
         | 32'($urandom_range(0, 3));
      doOp(ow, os, ol, ra, $urandom, $urandom_range(0, 3) == 0);
    end

    idleCycles(3);
    check("wrQ_drained", 32'(wrQ.size()), 0);
    check("cmpQ_drained", 32'(cmpQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access sequencer between the CPU's MEM stage and a synchronous-read word-wide data RAM. Turns load-word, store-word, load-byte and store-byte requests into RAM read and write cycles. Store-byte is done as a read-modify-write, and the CPU is stalled for the extra cycle. Load-byte returns the addressed byte zero-extended.

## Interface
Parameters:
- AW, 10, RAM word-address width; RAM holds 2^AW 32-bit words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  memory request valid from the MEM stage. The CPU holds req, we, sb, lb, addr and wdata stable while stall=1.
- we  in  1  store request (word, or byte if sb).
- sb  in  1  store-byte qualifier.
- lb  in  1  load-byte qualifier.
- addr  in  32  byte address; addr[1:0] selects the byte lane.
- wdata  in  32  store data; only bits [7:0] are used for sb.
- rdata  out  32  load result; valid only in the cycle where a load completes.
- stall  out  1  freeze the pipeline this cycle.
- mem_addr  out  AW  RAM word address, equal to addr[AW+1:2].
- mem_wdata  out  32  RAM write data.
- mem_we  out  1  RAM write enable; the write happens at the rising edge.
- mem_rdata  in  32  RAM read data; valid the cycle after the address is presented.

## Operation
Op decode, in priority order, only when req=1:
- sb=1: store byte (SB).
- we=1: store word (SW).
- lb=1: load byte (LB).
- otherwise: load word (LW).

Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].

FSM states are IDLE and RD_WAIT.

IDLE:
- req=0: no RAM activity; stall=0, mem_we=0, rdata=0.
- SW: mem_we=1, mem_wdata=wdata, stall=0. Stay in IDLE.
- LW, LB or SB: present mem_addr with mem_we=0, stall=1. Go to RD_WAIT and latch the op type and lane into registers.

RD_WAIT:
- LW: rdata=mem_rdata.
- LB: rdata={24'b0, selected byte of mem_rdata}.
- SB: mem_wdata=mem_rdata with the selected lane replaced by wdata[7:0]; all other lanes are unchanged. mem_we=1.
- In all three cases: stall=0, next state IDLE.

Other rules:
- addr[1:0] is ignored for LW and SW. There is no alignment exception.
- mem_addr is driven from addr in both states. The CPU's hold rule guarantees it is unchanged in RD_WAIT.
- If req drops while in RD_WAIT, the registered op still completes.

## Timing
- Reset: rst=1 forces state IDLE at once, asynchronously. Outputs go to stall=0, mem_we=0, rdata=0, mem_wdata=0.
- Reset asserted in RD_WAIT: the pending SB write is dropped. RAM contents are unchanged and no partial write occurs.
- Latency:
  - SW: 1 cycle, no stall.
  - LW, LB, SB: 2 cycles, with exactly one stall cycle (the first).
- Back-to-back: after RD_WAIT the FSM is in IDLE, so the next request is accepted in the following cycle with no bubble.
- Store followed by load to the same word: the RAM write commits at the edge ending the store cycle. The load's read in the next cycle returns the new data.
- Outputs are combinational from the state register, the latched op and the inputs. mem_rdata only reaches outputs in RD_WAIT.

## Structure
Shared package contents:
- state encoding: IDLE=1'b0, RD_WAIT=1'b1;
- op encoding: OP_LW=2'd0, OP_SW=2'd1, OP_LB=2'd2, OP_SB=2'd3;
- the lane constants.

One sub-module, byte_lane_unit, is purely combinational:
- inputs: word, byte, lane;
- outputs: the extracted byte, zero-extended, and the lane-merged word.

The FSM, the op/lane registers and the output muxing live in dmem_access_ctrl.

## Test plan
- Reset mid-op: issue SB, then assert rst during RD_WAIT → no write occurs, word unchanged, stall=0 and state IDLE immediately.
- SW then LW: SW addr=0x10, wdata=0xDEADBEEF → mem_we=1 with mem_addr=4 in the same cycle, stall=0. Then LW addr=0x10 → stall=1 for one cycle, then rdata=0xDEADBEEF.
- LB all lanes: word 0x44332211 at addr 0x20; LB addr 0x20..0x23 → rdata 0x11, 0x22, 0x33, 0x44. Each load stalls exactly one cycle.
- SB merge: word 0x44332211 at 0x20; SB addr=0x22, wdata=0xFFFFFFAA → mem_we in RD_WAIT with mem_wdata=0x44AA2211. A following LW returns 0x44AA2211.
- Priority and idle:
  - sb=lb=we=1 → treated as SB;
  - req=0 with random other inputs → mem_we=0, stall=0, rdata=0 for 20 cycles.
- Back-to-back: SB, LB, SW, LW on consecutive accepted requests → total 7 cycles, stall pattern 1,0,1,0,0,1,0, all data correct.
